cb_mem_responder: RTL



---
 rtl/cb_mem_responder_pkg.sv | 21 ++
 rtl/utils_pkg.sv | 44 ++++
 rtl/cb_mem_responder_if.sv | 11 +
 rtl/cb_ram_array.sv | 32 +++
 rtl/cb_mem_responder.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/cb_mem_responder_pkg.sv
// rtl/cb_mem_responder_pkg.sv - write FSM state and alignment helper local to the responder
package cb_mem_responder_pkg;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_DATA = 1'b1
    } wr_state_t;

    // Half-words need an even address, words a 4-byte aligned one; bytes are always fine.
    function automatic logic cb_misaligned(input utils_pkg::cb_size_t size, input logic [1:0] lsb);
        logic mis;
        mis = 1'b0;
        case (size)
            utils_pkg::CB_HALF_WORD: mis = lsb[0];
            utils_pkg::CB_WORD:      mis = |lsb;
            default:                 mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/utils_pkg.sv
// rtl/utils_pkg.sv - shared core-bus request/response types
package utils_pkg;

    typedef enum logic [1:0] {
        CB_BYTE      = 2'd0,
        CB_HALF_WORD = 2'd1,
        CB_WORD      = 2'd2
    } cb_size_t;

    typedef logic [3:0] cb_strb_t;

    typedef enum logic [1:0] {
        CB_OKAY   = 2'b00,
        CB_SLVERR = 2'b10
    } cb_resp_t;

    // Initiator -> responder
    typedef struct packed {
        logic [31:0] rd_addr;
        cb_size_t    rd_size;
        logic        rd_addr_valid;
        logic        rd_ready;
        logic [31:0] wr_addr;
        cb_size_t    wr_size;
        logic        wr_addr_valid;
        logic [31:0] wr_data;
        cb_strb_t    wr_strobe;
        logic        wr_data_valid;
        logic        wr_resp_ready;
    } s_cb_mosi_t;

    // Responder -> initiator
    typedef struct packed {
        logic        rd_addr_ready;
        logic        wr_addr_ready;
        logic [31:0] rd_data;
        cb_resp_t    rd_resp;
        logic        rd_valid;
        logic        wr_data_ready;
        cb_resp_t    wr_resp_error;
        logic        wr_resp_valid;
    } s_cb_miso_t;

endpackage

// File: rtl/cb_mem_responder_if.sv
// rtl/cb_mem_responder_if.sv - core-bus request/response bundle with initiator and responder views
interface cb_mem_responder_if;
    import utils_pkg::*;

    s_cb_mosi_t cb_mosi_i;
    s_cb_miso_t cb_miso_o;

    modport master (output cb_mosi_i, input cb_miso_o);
    modport slave  (input cb_mosi_i, output cb_miso_o);

endinterface

// File: rtl/cb_ram_array.sv
// rtl/cb_ram_array.sv - behavioural word SRAM, one synchronous read port, one byte-enable write port
module cb_ram_array #(
    parameter int WORDS = 2048,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [3:0]    wr_strobe,
    input  logic [31:0]   wr_data
);

    logic [31:0] mem [WORDS];

    // Byte-lane writes; a same-address read in the same cycle returns the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strobe[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/cb_mem_responder.sv
// rtl/cb_mem_responder.sv - core-bus SRAM responder with overlapped read/write channels
module cb_mem_responder
    import utils_pkg::*;
    import cb_mem_responder_pkg::*;
#(
    parameter int          MEM_KB    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    cb_mem_responder_if.slave cb
);

    localparam int          WORDS     = MEM_KB * 256;
    localparam int          AW        = $clog2(WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(MEM_KB * 1024);

    // Range check uses a 33-bit difference so addresses below the base show up as a borrow.
    function automatic logic addr_error(input logic [31:0] addr, input cb_size_t size);
        logic [32:0] diff;
        diff = {1'b0, addr} - {1'b0, BASE_ADDR};
        return diff[32] | (diff[31:0] >= MEM_BYTES) | cb_misaligned(size, addr[1:0]);
    endfunction

    s_cb_mosi_t req;
    s_cb_miso_t rsp;

    assign req = cb.cb_mosi_i;
    assign cb.cb_miso_o = rsp;

    logic [31:0]   rd_off;
    logic [31:0]   wr_off;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;
    logic          rd_err;
    logic          wr_err;

    assign rd_off = req.rd_addr - BASE_ADDR;
    assign wr_off = req.wr_addr - BASE_ADDR;
    assign rd_idx = rd_off[AW+1:2];
    assign wr_idx = wr_off[AW+1:2];
    assign rd_err = addr_error(req.rd_addr, req.rd_size);
    assign wr_err = addr_error(req.wr_addr, req.wr_size);

    logic unused_bits;
    assign unused_bits = ^{rd_off[31:AW+2], rd_off[1:0], wr_off[31:AW+2], wr_off[1:0], req.wr_resp_ready};

    // ---------------- write channel ----------------
    wr_state_t     wr_state;
    logic [AW-1:0] wr_idx_ff;
    cb_resp_t      wr_resp_ff;

    logic wr_addr_ready;
    logic wr_beat;
    logic wr_hs;
    logic wr_fire;

    assign wr_beat       = (wr_state == W_DATA) & req.wr_data_valid;
    assign wr_addr_ready = (wr_state == W_IDLE) | wr_beat;
    assign wr_hs         = req.wr_addr_valid & wr_addr_ready;
    assign wr_fire       = wr_beat & (wr_resp_ff == CB_OKAY);

    // Write FSM: capture address on handshake, finish on data beat, chain if a new address arrives with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state   <= W_IDLE;
            wr_idx_ff  <= '0;
            wr_resp_ff <= CB_OKAY;
        end else begin
            if (wr_hs) begin
                wr_state   <= W_DATA;
                wr_idx_ff  <= wr_idx;
                wr_resp_ff <= wr_err ? CB_SLVERR : CB_OKAY;
            end else if (wr_beat) begin
                wr_state   <= W_IDLE;
                wr_resp_ff <= CB_OKAY;
            end
        end
    end

    // ---------------- read channel ----------------
    logic        rd_pend_ff;
    cb_resp_t    rd_resp_ff;
    cb_strb_t    fwd_mask_ff;
    logic [31:0] fwd_data_ff;

    logic        rd_addr_ready;
    logic        rd_hs;
    logic [31:0] ram_q;
    logic [31:0] rd_merged;

    assign rd_addr_ready = ~rd_pend_ff | req.rd_ready;
    assign rd_hs         = req.rd_addr_valid & rd_addr_ready;

    // Read pending flag, response, and the byte lanes a same-cycle write to the same word overrides.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend_ff  <= 1'b0;
            rd_resp_ff  <= CB_OKAY;
            fwd_mask_ff <= '0;
            fwd_data_ff <= '0;
        end else begin
            if (rd_hs) begin
                rd_pend_ff  <= 1'b1;
                rd_resp_ff  <= rd_err ? CB_SLVERR : CB_OKAY;
                fwd_mask_ff <= (wr_fire && !rd_err && (wr_idx_ff == rd_idx)) ? req.wr_strobe : '0;
                fwd_data_ff <= req.wr_data;
            end else if (req.rd_ready) begin
                rd_pend_ff  <= 1'b0;
                rd_resp_ff  <= CB_OKAY;
                fwd_mask_ff <= '0;
            end
        end
    end

    // The array port only reads on an accepted in-range address, so its output holds through stalls.
    cb_ram_array #(
        .WORDS (WORDS),
        .AW    (AW)
    ) u_ram (
        .clk       (clk),
        .rd_en     (rd_hs & ~rd_err),
        .rd_addr   (rd_idx),
        .rd_data   (ram_q),
        .wr_en     (wr_fire),
        .wr_addr   (wr_idx_ff),
        .wr_strobe (req.wr_strobe),
        .wr_data   (req.wr_data)
    );

    // Write-first forwarding per byte lane for a read that met a write beat to the same word.
    always_comb begin
        rd_merged = ram_q;
        for (int i = 0; i < 4; i++) begin
            if (fwd_mask_ff[i]) begin
                rd_merged[8*i +: 8] = fwd_data_ff[8*i +: 8];
            end
        end
    end

    // Response bundle; data is zero unless an error-free read is pending.
    always_comb begin
        rsp               = '0;
        rsp.rd_addr_ready = rd_addr_ready;
        rsp.wr_addr_ready = wr_addr_ready;
        rsp.rd_valid      = rd_pend_ff;
        rsp.rd_resp       = rd_resp_ff;
        rsp.rd_data       = (rd_pend_ff && (rd_resp_ff == CB_OKAY)) ? rd_merged : 32'h0;
        rsp.wr_data_ready = (wr_state == W_DATA);
        rsp.wr_resp_error = (wr_state == W_DATA) ? wr_resp_ff : CB_OKAY;
        rsp.wr_resp_valid = wr_beat;
    end

endmodule
